// File: rtl/rpc_cmd_dispatch.sv
// Arbitrates AW/AR word requests into one DRAM command stream, gated on response-buffer space,
// and tags the last PHY read beat of each burst. Define RPC_DISPATCH_READ_PRIO_EN for fixed read priority.
module rpc_cmd_dispatch #(
  parameter int DramAddrWidth = 24,
  parameter int DramLenWidth  = 6,
  parameter int RdOutstanding = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     aw_valid_i,
  output logic                     aw_ready_o,
  input  logic [DramAddrWidth-1:0] aw_addr_i,
  input  logic [DramLenWidth-1:0]  aw_len_i,
  input  logic                     ar_valid_i,
  output logic                     ar_ready_o,
  input  logic [DramAddrWidth-1:0] ar_addr_i,
  input  logic [DramLenWidth-1:0]  ar_len_i,
  output logic                     trx_is_write_o,
  output logic [DramLenWidth-1:0]  trx_len_o,
  input  logic                     buf_resp_ready_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic                     cmd_is_write_o,
  output logic [DramAddrWidth-1:0] cmd_addr_o,
  output logic [DramLenWidth-1:0]  cmd_len_o,
  input  logic                     r_beat_valid_i,
  input  logic                     r_beat_ready_i,
  output logic                     r_phy_last_o,
  output logic                     err_o
);

  localparam int PtrW = (RdOutstanding > 1) ? $clog2(RdOutstanding) : 1;
  localparam int CntW = $clog2(RdOutstanding + 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                  state, state_nx;
  logic                    cand_valid, cand_write, accept;
  logic                    push, pop, beat, fifo_empty, fifo_full;
  logic [PtrW-1:0]         wr_ptr, rd_ptr;
  logic [CntW-1:0]         fifo_cnt;
  logic [DramLenWidth-1:0] beat_cnt;
  logic [DramLenWidth-1:0] len_mem [RdOutstanding];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RdOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CntW'(RdOutstanding));

`ifdef RPC_DISPATCH_READ_PRIO_EN
  assign cand_write = aw_valid_i && !ar_valid_i;
`else
  logic last_wr;

  // Alternate between write and read when both are requesting.
  assign cand_write = aw_valid_i && (!ar_valid_i || !last_wr);

  always_ff @(posedge clk_i) begin
    if (!rst_ni)     last_wr <= 1'b0;
    else if (accept) last_wr <= cand_write;
  end
`endif

  assign cand_valid = aw_valid_i || ar_valid_i;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_nx       = state;
    accept         = 1'b0;
    aw_ready_o     = 1'b0;
    ar_ready_o     = 1'b0;
    cmd_valid_o    = 1'b0;
    trx_is_write_o = 1'b0;
    trx_len_o      = '0;
    case (state)
      IDLE: begin
        if (cand_valid) begin
          trx_is_write_o = cand_write;
          trx_len_o      = cand_write ? aw_len_i : ar_len_i;
        end
        // A read blocked by a full length FIFO stalls arbitration; the write does not overtake it.
        accept     = cand_valid && buf_resp_ready_i && (cand_write || !fifo_full);
        aw_ready_o = accept && cand_write;
        ar_ready_o = accept && !cand_write;
        if (accept) state_nx = ISSUE;
      end
      ISSUE: begin
        cmd_valid_o    = 1'b1;
        trx_is_write_o = cmd_is_write_o;
        trx_len_o      = cmd_len_o;
        if (cmd_ready_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= IDLE;
      cmd_is_write_o <= 1'b0;
      cmd_addr_o     <= '0;
      cmd_len_o      <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cmd_is_write_o <= cand_write;
        cmd_addr_o     <= cand_write ? aw_addr_i : ar_addr_i;
        cmd_len_o      <= cand_write ? aw_len_i : ar_len_i;
      end
    end
  end

  assign push         = cmd_valid_o && cmd_ready_i && !cmd_is_write_o;
  assign beat         = r_beat_valid_i && r_beat_ready_i;
  assign r_phy_last_o = !fifo_empty && (beat_cnt == len_mem[rd_ptr]);
  assign pop          = beat && r_phy_last_o;

  // NOTE: the length storage has no reset; entries are only read while fifo_cnt marks them valid.
  always_ff @(posedge clk_i) begin
    if (push) len_mem[wr_ptr] <= cmd_len_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      beat_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (beat && fifo_empty)  err_o    <= 1'b1;
      else if (pop)            beat_cnt <= '0;
      else if (beat)           beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule
